// File: rtl/rtc_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_arb_pkg
// Description : Shared types and constants for the RTC write-engine arbiter
//               and its requesters.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_FIN = 2'd2,
        RELEASE  = 2'd3
    } arb_state_t;

    localparam int c_TIMEOUT_DEFAULT = 1024;

    // RTC command bytes issued by the requesters
    localparam logic [7:0] c_CMD_INIT = 8'hF0;
    localparam logic [7:0] c_CMD_EDIT = 8'hF1;
    localparam logic [7:0] c_CMD_READ = 8'hF2;

    function automatic int unsigned onehot_index(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_arbiter_if
// Description : Requester/engine-side bundle of the RTC bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rtc_bus_arbiter_if #(
    parameter int N = 3
);
    logic [N-1:0]   Req;
    logic [N-1:0]   Last;
    logic [8*N-1:0] Dir_in;
    logic [4*N-1:0] AddReg_in;
    logic [N-1:0]   SD_in;
    logic [N-1:0]   Cmd_in;
    logic           Fin;
    logic           Ciclo;
    logic [7:0]     DireccionF;
    logic [3:0]     AddRegF;
    logic           SDF;
    logic           CMDF;
    logic [N-1:0]   Grant;
    logic [N-1:0]   Done;
    logic [N-1:0]   Err;
    logic           Busy;

    modport slave (
        input  Req, Last, Dir_in, AddReg_in, SD_in, Cmd_in, Fin,
        output Ciclo, DireccionF, AddRegF, SDF, CMDF, Grant, Done, Err, Busy
    );

    modport master (
        output Req, Last, Dir_in, AddReg_in, SD_in, Cmd_in, Fin,
        input  Ciclo, DireccionF, AddRegF, SDF, CMDF, Grant, Done, Err, Busy
    );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : rtc_arb_pick
// Description : Combinational one-hot picker; search starts at i_ptr+1 mod N.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_arb_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [PW-1:0] i_ptr,
    output logic      [N-1:0]  o_pick
);

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        o_pick = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(i_ptr) + 1 + k) % N);
            if (!found && i_req[idx]) begin
                o_pick[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_arbiter
// Description : Grants the RTC write-cycle engine to one requester per burst,
//               muxes its fields and aborts hung cycles. RTC_ARB_RR_EN selects
//               round-robin instead of fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_arbiter
    import rtc_arb_pkg::*;
#(
    parameter int N       = 3,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input wire logic         Clock,
    input wire logic         Reset,
    rtc_bus_arbiter_if.slave arb_bus
);

    localparam int c_CW = $clog2(TIMEOUT);
    localparam int c_PW = (N > 1) ? $clog2(N) : 1;

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [N-1:0]      r_grant;
    logic [N-1:0]      r_done;
    logic [N-1:0]      r_err;
    logic [c_CW-1:0]   r_cnt;
    logic [N-1:0]      w_pick;
    logic [c_PW-1:0]   w_ptr;
    logic              w_any;
    logic              w_end_burst;
    logic              w_tmo;
    logic              w_ciclo;
    logic              w_busy;
    logic [7:0]        w_dir;
    logic [3:0]        w_areg;
    logic              w_sd;
    logic              w_cmd;

    assign w_any       = |arb_bus.Req;
    // A dropped request ends the burst at the next Fin just like Last
    assign w_end_burst = |(arb_bus.Last & r_grant) | ~|(arb_bus.Req & r_grant);
    assign w_tmo       = (r_cnt == c_CW'(TIMEOUT - 1));

`ifdef RTC_ARB_RR_EN
    logic [c_PW-1:0] r_ptr;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ptr <= c_PW'(N - 1);
        end else if (r_state == WAIT_FIN && w_next == RELEASE) begin
            r_ptr <= c_PW'(onehot_index(32'(r_grant)));
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = c_PW'(N - 1);
`endif

    rtc_arb_pick #(
        .N  (N),
        .PW (c_PW)
    ) u_pick (
        .i_req  (arb_bus.Req),
        .i_ptr  (w_ptr),
        .o_pick (w_pick)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_any) w_next = START;
            START:    w_next = WAIT_FIN;
            WAIT_FIN: begin
                if (arb_bus.Fin) begin
                    w_next = w_end_burst ? RELEASE : START;
                end else if (w_tmo) begin
                    w_next = RELEASE;
                end
            end
            RELEASE:  w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            if (r_state == IDLE && w_any) begin
                r_grant <= w_pick;
            end else if (r_state == WAIT_FIN && w_next == RELEASE) begin
                r_grant <= '0;
                if (arb_bus.Fin) begin
                    r_done <= r_grant;
                end else begin
                    r_err <= r_grant;
                end
            end
            // Counter is zero during START; it saturates at TIMEOUT-1
            if (w_next == START) begin
                r_cnt <= '0;
            end else if ((r_state == START || r_state == WAIT_FIN) && !w_tmo) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    always_comb begin
        w_ciclo = (r_state == START);
        w_busy  = (r_state != IDLE);
        w_dir   = '0;
        w_areg  = '0;
        w_sd    = 1'b0;
        w_cmd   = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_dir  = w_dir  | (arb_bus.Dir_in[8*i +: 8]    & {8{r_grant[i]}});
            w_areg = w_areg | (arb_bus.AddReg_in[4*i +: 4] & {4{r_grant[i]}});
            w_sd   = w_sd   | (arb_bus.SD_in[i]  & r_grant[i]);
            w_cmd  = w_cmd  | (arb_bus.Cmd_in[i] & r_grant[i]);
        end
    end

    assign arb_bus.Ciclo      = w_ciclo;
    assign arb_bus.Busy       = w_busy;
    assign arb_bus.DireccionF = w_dir;
    assign arb_bus.AddRegF    = w_areg;
    assign arb_bus.SDF        = w_sd;
    assign arb_bus.CMDF       = w_cmd;
    assign arb_bus.Grant      = r_grant;
    assign arb_bus.Done       = r_done;
    assign arb_bus.Err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_bus_arbiter
// Description : Directed self-checking bench with a grant/mux scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_arbiter;
    import rtc_arb_pkg::*;

    localparam int c_N   = 3;
    localparam int c_TMO = 16;

    typedef struct {
        logic [2:0] grant;
        logic [7:0] dir;
        logic [3:0] areg;
        logic       sd;
        logic       cmd;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    rtc_bus_arbiter_if #(.N(c_N)) bus ();

    rtc_bus_arbiter #(
        .N       (c_N),
        .TIMEOUT (c_TMO)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .arb_bus (bus)
    );

    exp_t       exp_q[$];
    logic [7:0] dir_v  [c_N];
    logic [3:0] areg_v [c_N];
    logic [2:0] sd_v;
    logic [2:0] cmd_v;
    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         n_ciclo = 0;
    int         last_wait = 0;
    int         c0;

    always @(negedge Clock) if (bus.Ciclo === 1'b1) n_ciclo++;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i);
        exp_t e;
        e.grant = 3'(1 << i);
        e.dir   = dir_v[i];
        e.areg  = areg_v[i];
        e.sd    = sd_v[i];
        e.cmd   = cmd_v[i];
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for a Ciclo pulse, then score the granted bus fields
    task automatic wait_ciclo(input string tag);
        exp_t e;
        int   k;
        for (k = 0; k < 40; k++) begin
            if (bus.Ciclo === 1'b1) break;
            tick();
        end
        last_wait = k;
        chk({tag, " ciclo"}, 32'(bus.Ciclo), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, " queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " bus"},
                32'({bus.Grant, bus.DireccionF, bus.AddRegF, bus.SDF, bus.CMDF}),
                32'({e.grant, e.dir, e.areg, e.sd, e.cmd}));
        end
    endtask

    task automatic fin_after(input int n);
        repeat (n - 1) tick();
        bus.Fin = 1'b1;
        tick();
        bus.Fin = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dir_v  = '{c_CMD_INIT, c_CMD_EDIT, c_CMD_READ};
        areg_v = '{4'h6, 4'hA, 4'h3};
        sd_v   = 3'b101;
        cmd_v  = 3'b010;
        bus.Req       = '0;
        bus.Last      = '0;
        bus.Fin       = 1'b0;
        bus.Dir_in    = {dir_v[2], dir_v[1], dir_v[0]};
        bus.AddReg_in = {areg_v[2], areg_v[1], areg_v[0]};
        bus.SD_in     = sd_v;
        bus.Cmd_in    = cmd_v;

        // Reset state
        repeat (3) tick();
        chk("rst grant", 32'(bus.Grant), 32'd0);
        chk("rst ciclo/busy", 32'({bus.Ciclo, bus.Busy}), 32'd0);
        chk("rst done/err", 32'({bus.Done, bus.Err}), 32'd0);
        chk("rst mux", 32'({bus.DireccionF, bus.AddRegF, bus.SDF, bus.CMDF}), 32'd0);
        Reset = 1'b0;

        // Four-transfer burst from requester 0
        c0 = n_ciclo;
        bus.Req = 3'b001;
        repeat (4) push(0);
        for (int b = 0; b < 4; b++) begin
            wait_ciclo("burst");
            chk("burst busy", 32'(bus.Busy), 32'd1);
            bus.Last = (b == 3) ? 3'b001 : 3'b000;
            fin_after(10);
            if (b < 3) chk("burst grant held", 32'(bus.Grant), 32'h1);
        end
        chk("burst done", 32'(bus.Done), 32'h1);
        chk("burst release", 32'({bus.Grant, bus.Ciclo}), 32'd0);
        bus.Req  = '0;
        bus.Last = '0;
        tick();
        chk("burst done once", 32'(bus.Done), 32'd0);
        chk("burst ciclo count", 32'(n_ciclo - c0), 32'd4);
        chk("burst idle", 32'(bus.Busy), 32'd0);

        // Simultaneous requests 1 and 2
        bus.Req  = 3'b110;
        bus.Last = 3'b110;
        push(1);
        push(2);
        wait_ciclo("pri1");
        fin_after(10);
        chk("pri done1", 32'(bus.Done), 32'h2);
        chk("pri release", 32'(bus.Grant), 32'd0);
        bus.Req = 3'b100;
        wait_ciclo("pri2");
        chk("pri gap", 32'(last_wait), 32'd2);
        fin_after(10);
        chk("pri done2", 32'(bus.Done), 32'h4);
        bus.Req  = '0;
        bus.Last = '0;
        repeat (2) tick();

        // Watchdog abort
        bus.Req = 3'b001;
        push(0);
        wait_ciclo("tmo");
        repeat (15) tick();
        chk("tmo early", 32'({bus.Grant, bus.Err}), 32'({3'b001, 3'b000}));
        tick();
        chk("tmo err", 32'({bus.Grant, bus.Err, bus.Done}), 32'({3'b000, 3'b001, 3'b000}));
        bus.Req = '0;
        tick();
        chk("tmo err pulse", 32'(bus.Err), 32'd0);
        tick();

        // Fin on the timeout cycle wins
        bus.Req  = 3'b001;
        bus.Last = 3'b001;
        push(0);
        wait_ciclo("race");
        repeat (15) tick();
        bus.Fin = 1'b1;
        tick();
        bus.Fin = 1'b0;
        chk("race done", 32'({bus.Done, bus.Err}), 32'({3'b001, 3'b000}));
        bus.Req  = '0;
        bus.Last = '0;
        repeat (2) tick();

        // Stray Fin in IDLE
        bus.Fin = 1'b1;
        tick();
        bus.Fin = 1'b0;
        chk("stray fin", 32'({bus.Done, bus.Err, bus.Busy, bus.Ciclo}), 32'd0);

        // Reset mid-transfer
        bus.Req = 3'b010;
        push(1);
        wait_ciclo("rstmid");
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        chk("rstmid grant/busy", 32'({bus.Grant, bus.Busy, bus.Ciclo}), 32'd0);
        chk("rstmid mux", 32'({bus.DireccionF, bus.AddRegF, bus.SDF, bus.CMDF}), 32'd0);
        Reset = 1'b0;
        push(1);
        wait_ciclo("restart");
        bus.Last = 3'b010;
        fin_after(10);
        chk("restart done", 32'(bus.Done), 32'h2);
        bus.Req  = '0;
        bus.Last = '0;
        repeat (2) tick();

        // Request dropped mid-burst
        bus.Req = 3'b010;
        push(1);
        wait_ciclo("drop");
        tick();
        c0 = n_ciclo;
        repeat (3) tick();
        bus.Req = '0;
        fin_after(6);
        chk("drop done", 32'({bus.Done, bus.Grant}), 32'({3'b010, 3'b000}));
        repeat (3) tick();
        chk("drop no ciclo", 32'(n_ciclo - c0), 32'd0);
        chk("drop idle", 32'(bus.Busy), 32'd0);

        // Grant order with all requesters held
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.Req  = 3'b111;
        bus.Last = 3'b111;
`ifdef RTC_ARB_RR_EN
        push(0); push(1); push(2); push(0);
`else
        push(0); push(0); push(0); push(0);
`endif
        for (int b = 0; b < 4; b++) begin
            wait_ciclo("order");
            fin_after(3);
        end
        bus.Req  = '0;
        bus.Last = '0;
        repeat (3) tick();
        chk("queue drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
Shares the single RTC write-cycle engine (the block producing A/D, CS, RD, WR timing with Sent_A/Sent_D/Fin) among several requesters:
- Requester 0: init programmer.
- Requester 1: user time/date edit writer.
- Requester 2: periodic reader.

It grants one requester at a time, pulses the engine's cycle-start input, and holds the grant across multi-cycle bursts until the requester flags its last transfer. It muxes the granted requester's Direccion/AddReg/SD/CMD fields onto the engine-side bus, and a watchdog aborts hung transfers.

Parameters:
N, 3, number of requesters (index 0 = highest fixed priority)
TIMEOUT, 1024, clock cycles allowed between a Ciclo pulse and Fin before abort (>=2)

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
Req  in  N  per-requester request; level, held until Done or Err
Last  in  N  per-requester flag; sampled at Fin: 1 = this engine cycle ends the burst
Dir_in  in  8*N  per-requester address/command byte, slice i = [8i+7:8i]
AddReg_in  in  4*N  per-requester data-register index
SD_in  in  N  per-requester send-data strobe
Cmd_in  in  N  per-requester command-select strobe
Fin  in  1  engine end-of-cycle pulse
Ciclo  out  1  one-cycle start pulse to the engine
DireccionF  out  8  muxed address to the datapath
AddRegF  out  4  muxed register index
SDF  out  1  muxed send strobe
CMDF  out  1  muxed command strobe
Grant  out  N  one-hot grant, registered
Done  out  N  one-cycle pulse to the requester when its burst completes
Err  out  N  one-cycle pulse to the requester on timeout abort
Busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock `Clock`; `Reset` is synchronous and active-high. On Reset, all registers clear the next edge, including mid-burst.
- Reset values: Grant=0, Ciclo=0, Done=0, Err=0, Busy=0, state=IDLE, timeout counter=0.
- Muxed outputs are combinational AND-OR of requester fields gated by Grant. With Grant=0, DireccionF=8'h00, AddRegF=4'h0, SDF=0, CMDF=0.
- FSM states: IDLE, START, WAIT_FIN, RELEASE.
  - IDLE: if any Req, select the winner; go to START.
  - START: Grant = winner, registered. Ciclo=1 for exactly this cycle. Timeout counter cleared. Next state WAIT_FIN.
  - WAIT_FIN, Fin=1 and (Last[g]=1 or Req[g]=0): Done[g]=1 next cycle; go to RELEASE.
  - WAIT_FIN, Fin=1 and Last[g]=0 and Req[g]=1: go to START; the next Ciclo comes 1 cycle after Fin and Grant is unchanged.
  - WAIT_FIN, counter reaches TIMEOUT-1 without Fin: Err[g]=1; go to RELEASE.
  - WAIT_FIN, otherwise: counter increments.
  - RELEASE: Grant=0 for one cycle (bus idle gap); go to IDLE.
- Latency: Req rising in IDLE at edge t gives Grant and Ciclo at t+1. Minimum gap between bursts of different requesters is 2 cycles (RELEASE + IDLE).
- Fixed priority: lowest index among asserted Req wins. Simultaneous requests resolve to index 0.
- Req deasserting mid-cycle: the engine cycle is not aborted. It is treated as Last at the next Fin.
- Fin arriving outside WAIT_FIN is ignored.
- Fin and timeout in the same cycle: Fin wins, no Err.
- Ungranted requesters see no Done/Err and must keep Req high.
- Counter width: $clog2(TIMEOUT). The counter saturates and does not wrap.

Optional Feature:
RTC_ARB_RR_EN
- Defined: round-robin arbitration. A registered last-winner pointer updates on each Done or Err. Search starts at pointer+1 modulo N. The pointer resets to N-1, so index 0 wins first after reset.
- Undefined: fixed priority as above, and no pointer register exists.

Decomposition:
- Package rtc_arb_pkg: state enum (IDLE, START, WAIT_FIN, RELEASE), default TIMEOUT, RTC command constants (8'hF0, 8'hF1, 8'hF2) shared with the requesters.
- Sub-module rtc_arb_pick: combinational N-bit one-hot picker with optional rotate pointer input. Used for both priority modes.

Test Plan:
- Req=3'b001, burst of 4 (Last=1 on the 4th Fin, Fin 10 cycles after each Ciclo) -> 4 Ciclo pulses, Grant=001 throughout, Done[0] once, one-cycle gap after the 4th Fin.
- Req=3'b110 simultaneously -> Grant=010 first. After Done[1], RELEASE then Grant=100. DireccionF tracks Dir_in slice 1, then slice 2.
- Granted, Fin never arrives, TIMEOUT=16 -> Err pulse 16 cycles after Ciclo, Grant=0 next cycle, no Done.
- Reset asserted in WAIT_FIN -> next edge: Grant=0, Busy=0, Ciclo=0, muxed outputs zero. Holding Req after reset release restarts with a fresh Ciclo.
- RTC_ARB_RR_EN defined, Req=3'b111 held, single-cycle bursts -> grant order 0,1,2,0.
- Req[1] dropped mid-burst with Last=0 -> at Fin: Done[1] and release, no further Ciclo.
